riscv_decode_stage: RTL and testbench

Registered instruction-decode pipeline stage for the RV32 core. Sits between fetch and execute. Accepts one instruction per cycle under a valid/ready handshake. Decodes the RV32I integer-computational subset, plus RV32M when configured, into ALU function, operand selects, immediate and register indices. Counts illegal instructions for debug.

---
 rtl/riscv_decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// riscv_decode_stage : registered RV32I decode stage (RV32M with RISCV_DECODE_RV32M_EN)
// Revision 1.0
// ============================================================================
module riscv_decode_stage #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [31:0]      in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [4:0]       exec_fun,
   output logic [1:0]       op1_sel,
   output logic             op2_sel,
   output logic [XLEN-1:0]  imm,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic             rf_wen,
   output logic             invalid_o,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [4:0] ALU_X    = 5'd0;
   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_SUB  = 5'd2;
   localparam logic [4:0] ALU_SLL  = 5'd3;
   localparam logic [4:0] ALU_SLT  = 5'd4;
   localparam logic [4:0] ALU_SLTU = 5'd5;
   localparam logic [4:0] ALU_XOR  = 5'd6;
   localparam logic [4:0] ALU_SRL  = 5'd7;
   localparam logic [4:0] ALU_SRA  = 5'd8;
   localparam logic [4:0] ALU_OR   = 5'd9;
   localparam logic [4:0] ALU_AND  = 5'd10;
`ifdef RISCV_DECODE_RV32M_EN
   localparam logic [4:0] ALU_MUL    = 5'd11;
   localparam logic [4:0] ALU_MULH   = 5'd12;
   localparam logic [4:0] ALU_MULHSU = 5'd13;
   localparam logic [4:0] ALU_MULHU  = 5'd14;
   localparam logic [4:0] ALU_DIV    = 5'd15;
   localparam logic [4:0] ALU_DIVU   = 5'd16;
   localparam logic [4:0] ALU_REM    = 5'd17;
   localparam logic [4:0] ALU_REMU   = 5'd18;
`endif

   localparam logic [1:0] OP1_RS1  = 2'd0;
   localparam logic [1:0] OP1_PC   = 2'd1;
   localparam logic [1:0] OP1_ZERO = 2'd2;
   localparam logic       OP2_RS2  = 1'b0;
   localparam logic       OP2_IMM  = 1'b1;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  dec_fun;
   logic [1:0]  dec_op1;
   logic        dec_op2;
   logic [31:0] dec_imm32;
   logic        dec_inv;
   logic        capture;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];

   always_comb begin
      dec_fun   = ALU_X;
      dec_op1   = OP1_RS1;
      dec_op2   = OP2_RS2;
      dec_imm32 = '0;
      dec_inv   = 1'b1;
      case (opcode)
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               dec_inv = 1'b0;
               case (funct3)
                  3'b000:  dec_fun = ALU_ADD;
                  3'b001:  dec_fun = ALU_SLL;
                  3'b010:  dec_fun = ALU_SLT;
                  3'b011:  dec_fun = ALU_SLTU;
                  3'b100:  dec_fun = ALU_XOR;
                  3'b101:  dec_fun = ALU_SRL;
                  3'b110:  dec_fun = ALU_OR;
                  default: dec_fun = ALU_AND;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_inv = 1'b0;
               dec_fun = ALU_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               dec_inv = 1'b0;
               dec_fun = ALU_SRA;
            end
`ifdef RISCV_DECODE_RV32M_EN
            else if (funct7 == 7'b0000001) begin
               dec_inv = 1'b0;
               case (funct3)
                  3'b000:  dec_fun = ALU_MUL;
                  3'b001:  dec_fun = ALU_MULH;
                  3'b010:  dec_fun = ALU_MULHSU;
                  3'b011:  dec_fun = ALU_MULHU;
                  3'b100:  dec_fun = ALU_DIV;
                  3'b101:  dec_fun = ALU_DIVU;
                  3'b110:  dec_fun = ALU_REM;
                  default: dec_fun = ALU_REMU;
               endcase
            end
`endif
         end
         OPC_OPIMM: begin
            dec_inv   = 1'b0;
            dec_op2   = OP2_IMM;
            dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            case (funct3)
               3'b000: dec_fun = ALU_ADD;
               3'b010: dec_fun = ALU_SLT;
               3'b011: dec_fun = ALU_SLTU;
               3'b100: dec_fun = ALU_XOR;
               3'b110: dec_fun = ALU_OR;
               3'b111: dec_fun = ALU_AND;
               3'b001: begin
                  dec_fun   = ALU_SLL;
                  dec_imm32 = {27'b0, in_inst[24:20]};
                  dec_inv   = (funct7 != 7'b0000000);
               end
               default: begin
                  dec_imm32 = {27'b0, in_inst[24:20]};
                  if (funct7 == 7'b0000000)
                     dec_fun = ALU_SRL;
                  else if (funct7 == 7'b0100000)
                     dec_fun = ALU_SRA;
                  else
                     dec_inv = 1'b1;
               end
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_inv   = 1'b0;
            dec_fun   = ALU_ADD;
            dec_op1   = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
            dec_op2   = OP2_IMM;
            dec_imm32 = {in_inst[31:12], 12'b0};
         end
         default: dec_inv = 1'b1;
      endcase
      // Partial decodes above may have set fields before the encoding proved illegal
      if (dec_inv) begin
         dec_fun   = ALU_X;
         dec_op1   = OP1_RS1;
         dec_op2   = OP2_RS2;
         dec_imm32 = '0;
      end
   end

   assign in_ready = !rst && !flush && (!out_valid || out_ready);
   assign capture  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         exec_fun    <= ALU_X;
         op1_sel     <= OP1_RS1;
         op2_sel     <= OP2_RS2;
         imm         <= '0;
         rs1         <= '0;
         rs2         <= '0;
         rd          <= '0;
         rf_wen      <= 1'b0;
         invalid_o   <= 1'b0;
         illegal_cnt <= '0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_pc    <= in_pc;
         exec_fun  <= dec_fun;
         op1_sel   <= dec_op1;
         op2_sel   <= dec_op2;
         imm       <= XLEN'($signed(dec_imm32));
         rs1       <= in_inst[19:15];
         rs2       <= in_inst[24:20];
         rd        <= in_inst[11:7];
         rf_wen    <= !dec_inv;
         invalid_o <= dec_inv;
         if (dec_inv && illegal_cnt != {CNT_W{1'b1}})
            illegal_cnt <= illegal_cnt + CNT_W'(1);
      end else if (flush || out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_riscv_decode_stage : directed scoreboard bench for riscv_decode_stage
// Revision 1.0
// ============================================================================
module tb_riscv_decode_stage;

   localparam int XLEN  = 32;
   localparam int PC_W  = 32;
   localparam int CNT_W = 2;

   localparam logic [4:0] ALU_X    = 5'd0;
   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_SUB  = 5'd2;
   localparam logic [4:0] ALU_SLL  = 5'd3;
   localparam logic [4:0] ALU_SLT  = 5'd4;
   localparam logic [4:0] ALU_SLTU = 5'd5;
   localparam logic [4:0] ALU_XOR  = 5'd6;
   localparam logic [4:0] ALU_SRL  = 5'd7;
   localparam logic [4:0] ALU_SRA  = 5'd8;
   localparam logic [4:0] ALU_OR   = 5'd9;
   localparam logic [4:0] ALU_AND  = 5'd10;
`ifdef RISCV_DECODE_RV32M_EN
   localparam logic [4:0] ALU_MUL  = 5'd11;
   localparam logic [4:0] ALU_REMU = 5'd18;
`endif
   localparam logic [1:0] OP1_RS1  = 2'd0;
   localparam logic [1:0] OP1_PC   = 2'd1;
   localparam logic [1:0] OP1_ZERO = 2'd2;
   localparam logic       OP2_RS2  = 1'b0;
   localparam logic       OP2_IMM  = 1'b1;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [4:0]  fun;
      logic [1:0]  op1;
      logic        op2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wen;
      logic        inv;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [PC_W-1:0]  in_pc;
   logic [31:0]      in_inst;
   logic             out_valid;
   logic             out_ready;
   logic [PC_W-1:0]  out_pc;
   logic [4:0]       exec_fun;
   logic [1:0]       op1_sel;
   logic             op2_sel;
   logic [XLEN-1:0]  imm;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [4:0]       rd;
   logic             rf_wen;
   logic             invalid_o;
   logic [CNT_W-1:0] illegal_cnt;

   exp_t             sb[$];
   exp_t             nop_e;
   exp_t             stream[8];
   logic [CNT_W-1:0] exp_cnt;
   logic             acc;
   int               nerr;
   int               nchecks;

   riscv_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .exec_fun(exec_fun), .op1_sel(op1_sel), .op2_sel(op2_sel), .imm(imm),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rf_wen(rf_wen), .invalid_o(invalid_o),
      .illegal_cnt(illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nchecks++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [4:0] fun, input logic [1:0] op1, input logic op2,
                               input logic [31:0] immv, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] rdv);
      exp_t e;
      e.inst = inst; e.pc = pc; e.fun = fun; e.op1 = op1; e.op2 = op2; e.imm = immv;
      e.rs1 = r1; e.rs2 = r2; e.rd = rdv; e.wen = 1'b1; e.inv = 1'b0;
      return e;
   endfunction

   function automatic exp_t bad(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv);
      exp_t e;
      e = mk(inst, pc, ALU_X, OP1_RS1, OP2_RS2, 32'h0, r1, r2, rdv);
      e.wen = 1'b0;
      e.inv = 1'b1;
      return e;
   endfunction

   // One cycle: drive at negedge, check held item / flags, update the scoreboard model
   task automatic drive(input logic v, input exp_t e, input logic ordy, input logic fl,
                        output logic accepted);
      logic held;
      logic exp_rdy;
      exp_t h;
      @(negedge clk);
      in_valid = v; in_inst = e.inst; in_pc = e.pc; out_ready = ordy; flush = fl;
      #1;
      held = (sb.size() != 0);
      check("out_valid", {63'b0, out_valid}, {63'b0, held});
      check("illegal_cnt", {62'b0, illegal_cnt}, {62'b0, exp_cnt});
      if (held) begin
         h = sb[0];
         check($sformatf("out_pc[%h]", h.inst), {32'b0, out_pc}, {32'b0, h.pc});
         check($sformatf("exec_fun[%h]", h.inst), {59'b0, exec_fun}, {59'b0, h.fun});
         check($sformatf("op1_sel[%h]", h.inst), {62'b0, op1_sel}, {62'b0, h.op1});
         check($sformatf("op2_sel[%h]", h.inst), {63'b0, op2_sel}, {63'b0, h.op2});
         check($sformatf("imm[%h]", h.inst), {32'b0, imm}, {32'b0, h.imm});
         check($sformatf("rs1[%h]", h.inst), {59'b0, rs1}, {59'b0, h.rs1});
         check($sformatf("rs2[%h]", h.inst), {59'b0, rs2}, {59'b0, h.rs2});
         check($sformatf("rd[%h]", h.inst), {59'b0, rd}, {59'b0, h.rd});
         check($sformatf("rf_wen[%h]", h.inst), {63'b0, rf_wen}, {63'b0, h.wen});
         check($sformatf("invalid_o[%h]", h.inst), {63'b0, invalid_o}, {63'b0, h.inv});
      end
      exp_rdy = !fl && (!held || ordy);
      check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
      if (held && (ordy || fl)) void'(sb.pop_front());
      accepted = v && exp_rdy;
      if (accepted) begin
         sb.push_back(e);
         if (e.inv && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h0;
      flush = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         #1;
         check("in_ready_in_rst", {63'b0, in_ready}, 64'd0);
         @(negedge clk);
      end
      rst = 1'b0; in_valid = 1'b0;
      sb.delete();
      exp_cnt = '0;
      #1;
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_out_pc", {32'b0, out_pc}, 64'd0);
      check("rst_exec_fun", {59'b0, exec_fun}, {59'b0, ALU_X});
      check("rst_op1_sel", {62'b0, op1_sel}, {62'b0, OP1_RS1});
      check("rst_op2_sel", {63'b0, op2_sel}, {63'b0, OP2_RS2});
      check("rst_imm", {32'b0, imm}, 64'd0);
      check("rst_regs", {49'b0, rs1, rs2, rd}, 64'd0);
      check("rst_rf_wen", {63'b0, rf_wen}, 64'd0);
      check("rst_invalid_o", {63'b0, invalid_o}, 64'd0);
      check("rst_illegal_cnt", {62'b0, illegal_cnt}, 64'd0);
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
   endtask

   initial begin
      nerr = 0; nchecks = 0; exp_cnt = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_inst = '0;
      nop_e = bad(32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

      do_reset(2);
      drive(1'b0, nop_e, 1'b0, 1'b0, acc);

      // Directed decodes, consumer always ready
      drive(1'b1, mk(32'h002081B3, 32'h100, ALU_ADD, OP1_RS1, OP2_RS2, 32'h0, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'hFFF00293, 32'h104, ALU_ADD, OP1_RS1, OP2_IMM, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd5), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h12345097, 32'h108, ALU_ADD, OP1_PC, OP2_IMM, 32'h12345000, 5'd8, 5'd3, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h4030D093, 32'h10C, ALU_SRA, OP1_RS1, OP2_IMM, 32'h3, 5'd1, 5'd3, 5'd1), 1'b1, 1'b0, acc);
`ifdef RISCV_DECODE_RV32M_EN
      drive(1'b1, mk(32'h023100B3, 32'h110, ALU_MUL, OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h023170B3, 32'h114, ALU_REMU, OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, acc);
`else
      drive(1'b1, bad(32'h023100B3, 32'h110, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, bad(32'h023170B3, 32'h114, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, acc);
`endif
      drive(1'b1, bad(32'h00000000, 32'h118, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, acc);
      drive(1'b1, bad(32'h40309093, 32'h11C, 5'd1, 5'd3, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, bad(32'hFFFFFFFF, 32'h120, 5'd31, 5'd31, 5'd31), 1'b1, 1'b0, acc);
      drive(1'b1, bad(32'h00000003, 32'h124, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, acc);
      drive(1'b1, bad(32'h002081B1, 32'h128, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, acc);
      drive(1'b1, bad(32'h403110B3, 32'h12C, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h800000B7, 32'h130, ALU_ADD, OP1_ZERO, OP2_IMM, 32'h80000000, 5'd0, 5'd0, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h80012093, 32'h134, ALU_SLT, OP1_RS1, OP2_IMM, 32'hFFFFF800, 5'd2, 5'd0, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h0FF14093, 32'h138, ALU_XOR, OP1_RS1, OP2_IMM, 32'h000000FF, 5'd2, 5'd31, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h0FF16093, 32'h13C, ALU_OR, OP1_RS1, OP2_IMM, 32'h000000FF, 5'd2, 5'd31, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h0FF17093, 32'h140, ALU_AND, OP1_RS1, OP2_IMM, 32'h000000FF, 5'd2, 5'd31, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'hFFF13093, 32'h144, ALU_SLTU, OP1_RS1, OP2_IMM, 32'hFFFFFFFF, 5'd2, 5'd31, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h01F15093, 32'h148, ALU_SRL, OP1_RS1, OP2_IMM, 32'h0000001F, 5'd2, 5'd31, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h00511093, 32'h14C, ALU_SLL, OP1_RS1, OP2_IMM, 32'h00000005, 5'd2, 5'd5, 5'd1), 1'b1, 1'b0, acc);
      drive(1'b1, mk(32'h403150B3, 32'h150, ALU_SRA, OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1), 1'b1, 1'b0, acc);

      // Back-to-back stream with out_ready cycling 1,0,0
      stream[0] = mk(32'h403100B3, 32'h300, ALU_SUB,  OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[1] = mk(32'h003110B3, 32'h304, ALU_SLL,  OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[2] = mk(32'h003120B3, 32'h308, ALU_SLT,  OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[3] = mk(32'h003130B3, 32'h30C, ALU_SLTU, OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[4] = mk(32'h003140B3, 32'h310, ALU_XOR,  OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[5] = mk(32'h003150B3, 32'h314, ALU_SRL,  OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[6] = mk(32'h003160B3, 32'h318, ALU_OR,   OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      stream[7] = mk(32'h003170B3, 32'h31C, ALU_AND,  OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1);
      begin
         int idx = 0;
         int cyc = 0;
         while (idx < 8 && cyc < 100) begin
            drive(1'b1, stream[idx], (cyc % 3) == 0, 1'b0, acc);
            if (acc) idx++;
            cyc++;
         end
      end
      repeat (3) drive(1'b0, nop_e, 1'b1, 1'b0, acc);

      // Reset while an instruction is held and another is stalled behind it
      drive(1'b1, mk(32'h002081B3, 32'h400, ALU_ADD, OP1_RS1, OP2_RS2, 32'h0, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0, acc);
      drive(1'b1, mk(32'h403100B3, 32'h404, ALU_SUB, OP1_RS1, OP2_RS2, 32'h0, 5'd2, 5'd3, 5'd1), 1'b0, 1'b0, acc);
      do_reset(1);

      // Flush while stalled with a pending offer, then flush together with out_ready
      drive(1'b1, mk(32'h002081B3, 32'h200, ALU_ADD, OP1_RS1, OP2_RS2, 32'h0, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0, acc);
      drive(1'b1, bad(32'h00000000, 32'h204, 5'd0, 5'd0, 5'd0), 1'b0, 1'b1, acc);
      drive(1'b1, bad(32'h00000000, 32'h204, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, acc);
      drive(1'b0, nop_e, 1'b0, 1'b0, acc);
      drive(1'b0, nop_e, 1'b1, 1'b1, acc);
      repeat (2) drive(1'b0, nop_e, 1'b1, 1'b0, acc);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
`default_nettype wire
